flex_counter_pro: RTL and testbench

- Parametrised successor to the team's basic flex counter, used for USB TX bit/byte timing and for packet-length tracking.
- Adds a programmable prescaler, an up/down direction, three terminal-count modes (wrap, saturate, one-shot), a synchronous load, a one-cycle rollover pulse and a done flag.
- Sits beside the TX encoder/timer FSMs and is driven by their strobes.

---
 rtl/flex_counter_pro.sv | 141 ++++++++++++++
 tb/tb_flex_counter_pro.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_pro.sv
// flex_counter_pro: prescaled up/down counter with wrap, saturate and
// one-shot terminal behaviour, synchronous clear/load, a registered
// rollover flag, a one-cycle rollover pulse and a sticky done flag.
// Count sequence runs between L = START_VALUE and H = rollover_value.
// Per-cycle priority: halt > clear > load > count_enable.
module flex_counter_pro #(
   parameter int NUM_CNT_BITS  = 4,
   parameter int PRESCALE_BITS = 4,
   parameter int START_VALUE   = 1
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     count_enable,
   input  logic                     clear,
   input  logic                     halt,
   input  logic                     load,
   input  logic [NUM_CNT_BITS-1:0]  load_value,
   input  logic [NUM_CNT_BITS-1:0]  rollover_value,
   input  logic [PRESCALE_BITS-1:0] prescale_value,
   input  logic                     dir,
   input  logic [1:0]               mode,
   output logic [NUM_CNT_BITS-1:0]  count_out,
   output logic                     rollover_flag,
   output logic                     rollover_pulse,
   output logic                     done
);

   // Terminal-count behaviour; encoding 11 behaves as wrap.
   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SAT      = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_WRAP_ALT = 2'b11
   } mode_t;

   localparam logic [NUM_CNT_BITS-1:0]  L_VAL    = NUM_CNT_BITS'(START_VALUE);
   localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
   localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);
   localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = '0;

   logic [NUM_CNT_BITS-1:0]  count_q,     count_n;
   logic [PRESCALE_BITS-1:0] prescaler_q, prescaler_n;
   logic                     flag_q,      flag_n;
   logic                     pulse_q,     pulse_n;
   logic                     done_q,      done_n;

   logic [NUM_CNT_BITS-1:0]  start_val;
   logic [NUM_CNT_BITS-1:0]  step_val;
   logic                     cur_term;
   logic                     tick;
   mode_t                    mode_sel;

   // Terminal test uses >= / <= so a count left outside [L,H] (bound
   // lowered under it, or an out-of-range load) is treated as terminal.
   function automatic logic is_terminal(input logic [NUM_CNT_BITS-1:0] c,
                                        input logic                    down,
                                        input logic [NUM_CNT_BITS-1:0] hi);
      if (down) return (c <= L_VAL);
      else      return (c >= hi);
   endfunction

   assign mode_sel  = mode_t'(mode);
   assign start_val = dir ? rollover_value : L_VAL;
   assign step_val  = dir ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
   assign cur_term  = is_terminal(count_q, dir, rollover_value);
   // >= so that lowering prescale_value below the running prescaler
   // still ticks on the next enable instead of waiting for wraparound.
   assign tick      = count_enable && (prescaler_q >= prescale_value);

   // Next-state logic: holds by default, pulse defaults low.
   always_comb begin
      count_n     = count_q;
      prescaler_n = prescaler_q;
      flag_n      = flag_q;
      pulse_n     = 1'b0;
      done_n      = done_q;

      if (halt) begin
         // everything frozen, pulse forced low
      end else if (clear) begin
         count_n     = start_val;
         prescaler_n = PRE_ZERO;
         done_n      = 1'b0;
         flag_n      = is_terminal(start_val, dir, rollover_value);
      end else if (load) begin
         count_n     = load_value;
         prescaler_n = PRE_ZERO;
         done_n      = 1'b0;
         flag_n      = is_terminal(load_value, dir, rollover_value);
      end else if (count_enable) begin
         prescaler_n = tick ? PRE_ZERO : (prescaler_q + PRE_ONE);
         if (tick && !done_q) begin
            if (!cur_term) begin
               count_n = step_val;
               flag_n  = is_terminal(step_val, dir, rollover_value);
               pulse_n = is_terminal(step_val, dir, rollover_value);
            end else begin
               case (mode_sel)
                  MODE_SAT: begin
                     flag_n = 1'b1;
                  end
                  MODE_ONESHOT: begin
                     count_n = start_val;
                     flag_n  = is_terminal(start_val, dir, rollover_value);
                     done_n  = 1'b1;
                  end
                  default: begin
                     // wrap (00 and 11); pulses again only when L >= H
                     count_n = start_val;
                     flag_n  = is_terminal(start_val, dir, rollover_value);
                     pulse_n = is_terminal(start_val, dir, rollover_value);
                  end
               endcase
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q     <= L_VAL;
         prescaler_q <= PRE_ZERO;
         flag_q      <= 1'b0;
         pulse_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         count_q     <= count_n;
         prescaler_q <= prescaler_n;
         flag_q      <= flag_n;
         pulse_q     <= pulse_n;
         done_q      <= done_n;
      end
   end

   assign count_out      = count_q;
   assign rollover_flag  = flag_q;
   assign rollover_pulse = pulse_q;
   assign done           = done_q;

endmodule

// File: tb/tb_flex_counter_pro.sv
// tb_flex_counter_pro: directed-vector bench for flex_counter_pro with
// default parameters (4-bit count, 4-bit prescaler, START_VALUE = 1).
module tb_flex_counter_pro;

   logic       clk;
   logic       n_rst;
   logic       count_enable;
   logic       clear;
   logic       halt;
   logic       load;
   logic [3:0] load_value;
   logic [3:0] rollover_value;
   logic [3:0] prescale_value;
   logic       dir;
   logic [1:0] mode;
   logic [3:0] count_out;
   logic       rollover_flag;
   logic       rollover_pulse;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] exp_q[$];

   flex_counter_pro #(
      .NUM_CNT_BITS (4),
      .PRESCALE_BITS(4),
      .START_VALUE  (1)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .count_enable  (count_enable),
      .clear         (clear),
      .halt          (halt),
      .load          (load),
      .load_value    (load_value),
      .rollover_value(rollover_value),
      .prescale_value(prescale_value),
      .dir           (dir),
      .mode          (mode),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .rollover_pulse(rollover_pulse),
      .done          (done)
   );

   // clock: 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      else
         n_pass++;
   endtask

   // advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int c, input int f, input int p, input int d);
      check($sformatf("%s.count", tag), 32'(count_out),      c);
      check($sformatf("%s.flag",  tag), 32'(rollover_flag),  f);
      check($sformatf("%s.pulse", tag), 32'(rollover_pulse), p);
      check($sformatf("%s.done",  tag), 32'(done),           d);
   endtask

   initial begin
      int t2_en[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      int t2_c[10]  = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 1};
      int t2_f[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      int t2_p[10]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      int t3w_c[6]  = '{5, 4, 3, 2, 1, 6};
      int t3w_f[6]  = '{0, 0, 0, 0, 1, 0};
      int t3s_c[7]  = '{5, 4, 3, 2, 1, 1, 1};
      int t3s_f[7]  = '{0, 0, 0, 0, 1, 1, 1};
      int t3s_p[7]  = '{0, 0, 0, 0, 1, 0, 0};
      int t4_c[5]   = '{2, 3, 1, 1, 1};
      int t4_f[5]   = '{0, 1, 0, 0, 0};
      int t4_p[5]   = '{0, 1, 0, 0, 0};
      int t4_d[5]   = '{0, 0, 1, 1, 1};
      logic [3:0] exp_c;

      // reset with wrap/up defaults, H = 5, prescale 0
      n_rst          = 1'b0;
      count_enable   = 1'b0;
      clear          = 1'b0;
      halt           = 1'b0;
      load           = 1'b0;
      load_value     = 4'd0;
      rollover_value = 4'd5;
      prescale_value = 4'd0;
      dir            = 1'b0;
      mode           = 2'b00;
      step();
      step();
      check_all("reset", 1, 0, 0, 0);

      // 1: up count, wrap at 5, enable held
      n_rst        = 1'b1;
      count_enable = 1'b1;
      exp_q = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
      while (exp_q.size() > 0) begin
         step();
         exp_c = exp_q.pop_front();
         check_all($sformatf("up_wrap_c%0d", exp_c), 32'(exp_c),
                   (exp_c == 4'd5) ? 1 : 0, (exp_c == 4'd5) ? 1 : 0, 0);
      end

      // 2: prescale 2, H = 3, with an enable gap
      count_enable   = 1'b0;
      prescale_value = 4'd2;
      rollover_value = 4'd3;
      clear          = 1'b1;
      step();
      check_all("pre_clear", 1, 0, 0, 0);
      clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         count_enable = t2_en[i][0];
         step();
         check_all($sformatf("pre_%0d", i), t2_c[i], t2_f[i], t2_p[i], 0);
      end

      // 3a: down count, H = 6, wrap
      count_enable   = 1'b0;
      prescale_value = 4'd0;
      rollover_value = 4'd6;
      dir            = 1'b1;
      clear          = 1'b1;
      step();
      check_all("dn_clear", 6, 0, 0, 0);
      clear        = 1'b0;
      count_enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check_all($sformatf("dn_wrap_%0d", i), t3w_c[i], t3w_f[i], t3w_f[i], 0);
      end

      // 3b: down count, saturate
      count_enable = 1'b0;
      mode         = 2'b01;
      clear        = 1'b1;
      step();
      check_all("sat_clear", 6, 0, 0, 0);
      clear        = 1'b0;
      count_enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check_all($sformatf("dn_sat_%0d", i), t3s_c[i], t3s_f[i], t3s_p[i], 0);
      end

      // 4: one-shot, up, H = 3
      count_enable   = 1'b0;
      dir            = 1'b0;
      mode           = 2'b10;
      rollover_value = 4'd3;
      clear          = 1'b1;
      step();
      check_all("os_clear", 1, 0, 0, 0);
      clear        = 1'b0;
      count_enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_all($sformatf("os_%0d", i), t4_c[i], t4_f[i], t4_p[i], t4_d[i]);
      end
      count_enable = 1'b0;
      clear        = 1'b1;
      step();
      check_all("os_reclear", 1, 0, 0, 0);
      clear        = 1'b0;
      count_enable = 1'b1;
      step();
      check_all("os_resume", 2, 0, 0, 0);

      // 5: priority and out-of-range load, wrap, H = 5
      mode           = 2'b00;
      rollover_value = 4'd5;
      step();
      check_all("pri_c3", 3, 0, 0, 0);
      step();
      check_all("pri_c4", 4, 0, 0, 0);
      halt       = 1'b1;
      clear      = 1'b1;
      load       = 1'b1;
      load_value = 4'd9;
      step();
      check_all("pri_all", 4, 0, 0, 0);
      halt  = 1'b0;
      clear = 1'b0;
      load  = 1'b0;
      step();
      check_all("pri_c5", 5, 1, 1, 0);
      halt = 1'b1;
      step();
      check_all("pri_halt", 5, 1, 0, 0);
      halt  = 1'b0;
      clear = 1'b1;
      load  = 1'b1;
      step();
      check_all("pri_clr_ld", 1, 0, 0, 0);
      clear = 1'b0;
      step();
      check_all("pri_ld9", 9, 1, 0, 0);
      load = 1'b0;
      step();
      check_all("pri_ld_wrap", 1, 0, 0, 0);

      // 6: async reset mid-count with count 4 and prescaler 1
      count_enable   = 1'b0;
      prescale_value = 4'd1;
      rollover_value = 4'd4;
      clear          = 1'b1;
      step();
      clear        = 1'b0;
      count_enable = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check_all("rst_pre_c4", 4, 1, 1, 0);
      step();
      check_all("rst_pre_p1", 4, 1, 0, 0);
      count_enable = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      check_all("rst_async", 1, 0, 0, 0);
      #1 n_rst = 1'b1;
      count_enable = 1'b1;
      step();
      check_all("rst_after_1", 1, 0, 0, 0);
      step();
      check_all("rst_after_2", 2, 0, 0, 0);
      step();
      step();
      check_all("rst_after_4", 3, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
